// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and helpers for the sprite blitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sprite_pkg;

    localparam int SCREEN_W_DEF    = 480;
    localparam int SCREEN_H_DEF    = 272;
    localparam int SPRITE_SIZE_DEF = 32;
    localparam int MAX_SCALE_DEF   = 2;

    localparam int ID_W       = 8;
    localparam int COORD_W    = 16;
    localparam int SCALE_IN_W = 8;
    localparam int SCALE_W    = 2;
    localparam int PIX_W      = 8;
    localparam int FB_ADDR_W  = 17;
    localparam int ROM_ADDR_W = 18;

    localparam logic [PIX_W-1:0] TRANSPARENT_IDX = 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAW  = 2'd2,
        FLUSH = 2'd3
    } blit_state_e;

    // Saturate the requested scale shift to the largest supported shift.
    function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_IN_W-1:0] s,
                                                       input int max_s);
        logic [SCALE_W-1:0] r;
        if (int'(s) > max_s) begin
            r = SCALE_W'(max_s);
        end else begin
            r = s[SCALE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Destination scan counter: walks dx/dy over the scaled edge, yields source sx/sy.
// Latency: combinational outputs from the current counter values; advances one pixel per clock.
// Backpressure: none; advances whenever advance_i is high, clear_i restarts at (0,0).
module blit_addr_gen
    import sprite_pkg::*;
#(
    parameter int SRC_W     = 5,
    parameter int MAX_SCALE = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          clear_i,
    input  logic                          advance_i,
    input  logic [SCALE_W-1:0]            scale_i,
    output logic [SRC_W+MAX_SCALE-1:0]    dx_o,
    output logic [SRC_W+MAX_SCALE-1:0]    dy_o,
    output logic [SRC_W-1:0]              sx_o,
    output logic [SRC_W-1:0]              sy_o,
    output logic                          last_o
);

    localparam int CW = SRC_W + MAX_SCALE;

    logic [CW-1:0] dx_q, dx_d;
    logic [CW-1:0] dy_q, dy_d;
    logic [CW-1:0] edge_m1;

    // Drawn edge minus one: all-ones of width SRC_W+scale.
    assign edge_m1 = {CW{1'b1}} >> (SCALE_W'(MAX_SCALE) - scale_i);

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign sx_o   = SRC_W'(dx_q >> scale_i);
    assign sy_o   = SRC_W'(dy_q >> scale_i);
    assign last_o = (dx_q == edge_m1) && (dy_q == edge_m1);

    // Raster step: dx runs across the row, wraps to 0 and bumps dy at the edge.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clear_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (advance_i) begin
            if (dx_q == edge_m1) begin
                dx_d = '0;
                dy_d = dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Pops sprite descriptors and writes scaled, clipped, non-transparent pixels to the framebuffer.
// Latency: pop to first rom_addr 2 clocks, rom_addr to fb_we 2 clocks, one destination pixel per clock.
// Backpressure: pops only while enable && !is_empty in IDLE; an in-progress sprite always completes.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
    parameter int MAX_SCALE   = MAX_SCALE_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    is_empty,
    input  logic [ID_W-1:0]         sprite_id,
    input  logic [COORD_W-1:0]      sprite_x,
    input  logic [COORD_W-1:0]      sprite_y,
    input  logic [SCALE_IN_W-1:0]   sprite_scale,
    output logic                    dequeue,
    output logic [ROM_ADDR_W-1:0]   rom_addr,
    input  logic [PIX_W-1:0]        rom_data,
    output logic                    fb_we,
    output logic [FB_ADDR_W-1:0]    fb_addr,
    output logic [PIX_W-1:0]        fb_data,
    output logic                    busy,
    output logic                    sprite_done
);

    localparam int SRC_W = $clog2(SPRITE_SIZE);
    localparam int CW    = SRC_W + MAX_SCALE;

    blit_state_e state_q, state_d;

    logic                  pop, gen_clear, issue, done_d;
    logic                  dequeue_q, sprite_done_q;
    logic [ID_W-1:0]       id_q;
    logic [COORD_W-1:0]    x_q, y_q;
    logic [SCALE_IN_W-1:0] scale_raw_q;
    logic [SCALE_W-1:0]    scale_q;

    logic [CW-1:0]         dx, dy;
    logic [SRC_W-1:0]      sx, sy;
    logic                  last_pix;

    logic [FB_ADDR_W-1:0]  dest_x, dest_y, dest_addr;
    logic                  dest_on;

    logic [ROM_ADDR_W-1:0] rom_addr_q;
    logic                  s1_vld_q, s1_on_q, s2_vld_q, s2_on_q;
    logic [FB_ADDR_W-1:0]  s1_addr_q, s2_addr_q;
    logic                  wr_hit;
    logic                  fb_we_q;
    logic [FB_ADDR_W-1:0]  fb_addr_q;
    logic [PIX_W-1:0]      fb_data_q;

    blit_addr_gen #(
        .SRC_W     (SRC_W),
        .MAX_SCALE (MAX_SCALE)
    ) u_addr_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (gen_clear),
        .advance_i (issue),
        .scale_i   (scale_q),
        .dx_o      (dx),
        .dy_o      (dy),
        .sx_o      (sx),
        .sy_o      (sy),
        .last_o    (last_pix)
    );

    // Destination coordinates are formed wide enough that x+dx / y+dy never wrap.
    assign dest_x    = FB_ADDR_W'(x_q) + FB_ADDR_W'(dx);
    assign dest_y    = FB_ADDR_W'(y_q) + FB_ADDR_W'(dy);
    assign dest_on   = (dest_x < FB_ADDR_W'(SCREEN_W)) && (dest_y < FB_ADDR_W'(SCREEN_H));
    assign dest_addr = dest_y * FB_ADDR_W'(SCREEN_W) + dest_x;

    assign issue  = (state_q == DRAW);
    assign wr_hit = s2_vld_q && s2_on_q && (rom_data != TRANSPARENT_IDX);

    // FSM next state: pop in IDLE, restart scan in LOAD, scan in DRAW, drain in FLUSH.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        gen_clear = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !is_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                gen_clear = 1'b1;
                state_d   = DRAW;
            end
            DRAW: begin
                if (last_pix) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Leave once both pipe stages behind the last address have emptied.
                if (!s1_vld_q && !s2_vld_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, pop strobe, done pulse and latched descriptor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            dequeue_q     <= 1'b0;
            sprite_done_q <= 1'b0;
            id_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            scale_raw_q   <= '0;
            scale_q       <= '0;
        end else begin
            state_q       <= state_d;
            dequeue_q     <= pop;
            sprite_done_q <= done_d;
            if (pop) begin
                id_q        <= sprite_id;
                x_q         <= sprite_x;
                y_q         <= sprite_y;
                scale_raw_q <= sprite_scale;
            end
            if (state_q == LOAD) begin
                scale_q <= clamp_scale(scale_raw_q, MAX_SCALE);
            end
        end
    end

    // ROM address register and the 2-deep destination pipe matching ROM latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            s1_vld_q   <= 1'b0;
            s1_on_q    <= 1'b0;
            s1_addr_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_on_q    <= 1'b0;
            s2_addr_q  <= '0;
        end else begin
            if (issue) begin
                rom_addr_q <= {id_q, sy, sx};
                s1_on_q    <= dest_on;
                s1_addr_q  <= dest_addr;
            end
            s1_vld_q  <= issue;
            s2_vld_q  <= s1_vld_q;
            s2_on_q   <= s1_on_q;
            s2_addr_q <= s1_addr_q;
        end
    end

    // Registered framebuffer write port; strobe drops on every non-write clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            fb_we_q <= wr_hit;
            if (wr_hit) begin
                fb_addr_q <= s2_addr_q;
                fb_data_q <= rom_data;
            end
        end
    end

    assign dequeue     = dequeue_q;
    assign rom_addr    = rom_addr_q;
    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_data     = fb_data_q;
    assign busy        = (state_q != IDLE);
    assign sprite_done = sprite_done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a behavioural sprite ROM and a write monitor.
// Latency: checks pop->rom_addr, rom_addr->fb_we and per-sprite duration.
// Backpressure: exercises is_empty/enable gating and mid-sprite enable drop.
module tb_sprite_blitter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        is_empty;
    logic [7:0]  sprite_id;
    logic [15:0] sprite_x;
    logic [15:0] sprite_y;
    logic [7:0]  sprite_scale;
    logic        dequeue;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        busy;
    logic        sprite_done;

    int checks = 0;
    int errors = 0;
    int rom_mode = 0;

    // Monitor state (written only by the monitor process).
    int cyc = 0;
    int pops = 0;
    int deq_hi = 0;
    logic deq_prev = 1'b0;
    int pop_cyc = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    int first_we_cyc = 0;
    int col200 = 0;
    int oob = 0;
    logic [16:0] first_addr = '0;
    logic [16:0] last_addr = '0;
    logic [7:0] fb_mem [131072];

    sprite_blitter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .is_empty     (is_empty),
        .sprite_id    (sprite_id),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_scale (sprite_scale),
        .dequeue      (dequeue),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .busy         (busy),
        .sprite_done  (sprite_done)
    );

    always #5 clock = ~clock;

    // Sprite ROM: bit7 set so pixels are never 0 unless mode 1 blanks source column 0.
    function automatic logic [7:0] rom_fn(input logic [17:0] a);
        logic [7:0] v;
        v = {1'b1, a[6:5], a[4:0]} ^ a[17:10];
        if (rom_mode == 1 && a[4:0] == 5'd0) v = 8'd0;
        return v;
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        rom_data <= rom_fn(rom_addr);
    end

    always @(negedge clock) begin
        if (dequeue) begin
            if (!deq_prev) begin
                pops = pops + 1;
                pop_cyc = cyc;
                deq_hi = 1;
                wr_cnt = 0;
                col200 = 0;
                oob = 0;
            end else begin
                deq_hi = deq_hi + 1;
            end
        end
        deq_prev = dequeue;
        if (sprite_done) done_cyc = cyc;
        if (fb_we) begin
            if (wr_cnt == 0) begin
                first_addr = fb_addr;
                first_we_cyc = cyc;
            end
            last_addr = fb_addr;
            wr_cnt = wr_cnt + 1;
            fb_mem[fb_addr] = fb_data;
            if ((int'(fb_addr) % 480) == 200) col200 = col200 + 1;
            if (int'(fb_addr) >= 130560) oob = oob + 1;
        end
    end

    task automatic push(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                        input logic [7:0] s, output bit ok);
        @(negedge clock);
        sprite_id = id; sprite_x = x; sprite_y = y; sprite_scale = s;
        is_empty = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (dequeue) begin
                ok = 1'b1;
                break;
            end
        end
        is_empty = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sprite_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (dequeue !== 1'b0) begin errors++; $display("FAIL reset_dequeue got=%b exp=0", dequeue); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got=%b exp=0", fb_we); end
        checks++; if (fb_addr !== 17'd0) begin errors++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr); end
        checks++; if (fb_data !== 8'd0) begin errors++; $display("FAIL reset_fb_data got=%0d exp=0", fb_data); end
        checks++; if (rom_addr !== 18'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sprite_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", sprite_done); end
        reset_n = 1'b1;
    endtask

    task automatic test_no_pop();
        int p0;
        p0 = pops;
        enable = 1'b1; is_empty = 1'b1;
        repeat (30) @(negedge clock);
        checks++; if (pops !== p0) begin errors++; $display("FAIL nopop_empty got=%0d exp=%0d", pops, p0); end
        enable = 1'b0; is_empty = 1'b0;
        repeat (30) @(negedge clock);
        checks++; if (pops !== p0) begin errors++; $display("FAIL nopop_disabled got=%0d exp=%0d", pops, p0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nopop_busy got=%b exp=0", busy); end
        is_empty = 1'b1; enable = 1'b1;
    endtask

    task automatic test_opaque();
        bit ok;
        int p0;
        rom_mode = 0;
        p0 = pops;
        push(8'd0, 16'd200, 16'd200, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL opaque_pop got=timeout exp=dequeue"); end
        wait_done(1200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL opaque_done got=timeout exp=sprite_done"); end
        checks++; if (wr_cnt !== 1024) begin errors++; $display("FAIL opaque_writes got=%0d exp=1024", wr_cnt); end
        checks++; if (first_addr !== 17'd96200) begin errors++; $display("FAIL opaque_first got=%0d exp=96200", first_addr); end
        checks++; if (last_addr !== 17'd111111) begin errors++; $display("FAIL opaque_last got=%0d exp=111111", last_addr); end
        checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL opaque_pops got=%0d exp=1", pops - p0); end
        checks++; if (deq_hi !== 1) begin errors++; $display("FAIL opaque_deq_width got=%0d exp=1", deq_hi); end
        checks++; if (done_cyc - pop_cyc !== 1028) begin errors++; $display("FAIL opaque_duration got=%0d exp=1028", done_cyc - pop_cyc); end
        checks++; if (first_we_cyc - pop_cyc !== 4) begin errors++; $display("FAIL opaque_first_we_lat got=%0d exp=4", first_we_cyc - pop_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL opaque_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_transparent();
        bit ok;
        rom_mode = 1;
        push(8'd5, 16'd200, 16'd200, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL transp_pop got=timeout exp=dequeue"); end
        @(negedge clock);
        @(negedge clock);
        checks++; if (rom_addr !== 18'h01400) begin errors++; $display("FAIL transp_rom_first got=%h exp=01400", rom_addr); end
        @(negedge clock);
        checks++; if (rom_addr !== 18'h01401) begin errors++; $display("FAIL transp_rom_second got=%h exp=01401", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL transp_busy got=%b exp=1", busy); end
        wait_done(1200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL transp_done got=timeout exp=sprite_done"); end
        checks++; if (wr_cnt !== 992) begin errors++; $display("FAIL transp_writes got=%0d exp=992", wr_cnt); end
        checks++; if (col200 !== 0) begin errors++; $display("FAIL transp_col200 got=%0d exp=0", col200); end
        rom_mode = 0;
    endtask

    task automatic test_scale1();
        bit ok;
        push(8'd0, 16'd0, 16'd0, 8'd1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL scale1_pop got=timeout exp=dequeue"); end
        wait_done(4200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL scale1_done got=timeout exp=sprite_done"); end
        checks++; if (wr_cnt !== 4096) begin errors++; $display("FAIL scale1_writes got=%0d exp=4096", wr_cnt); end
        checks++; if (done_cyc - pop_cyc !== 4100) begin errors++; $display("FAIL scale1_duration got=%0d exp=4100", done_cyc - pop_cyc); end
        checks++; if (fb_mem[0] !== 8'h80) begin errors++; $display("FAIL scale1_px00 got=%h exp=80", fb_mem[0]); end
        checks++; if (fb_mem[1] !== 8'h80) begin errors++; $display("FAIL scale1_px10 got=%h exp=80", fb_mem[1]); end
        checks++; if (fb_mem[480] !== 8'h80) begin errors++; $display("FAIL scale1_px01 got=%h exp=80", fb_mem[480]); end
        checks++; if (fb_mem[481] !== 8'h80) begin errors++; $display("FAIL scale1_px11 got=%h exp=80", fb_mem[481]); end
        checks++; if (fb_mem[2] !== 8'h81) begin errors++; $display("FAIL scale1_px20 got=%h exp=81", fb_mem[2]); end
    endtask

    task automatic test_scale_clamp();
        bit ok;
        push(8'd0, 16'd0, 16'd0, 8'd7, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_pop got=timeout exp=dequeue"); end
        wait_done(16500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_done got=timeout exp=sprite_done"); end
        checks++; if (wr_cnt !== 16384) begin errors++; $display("FAIL clamp_writes got=%0d exp=16384", wr_cnt); end
        checks++; if (done_cyc - pop_cyc !== 16388) begin errors++; $display("FAIL clamp_duration got=%0d exp=16388", done_cyc - pop_cyc); end
        checks++; if (last_addr !== 17'd61087) begin errors++; $display("FAIL clamp_last got=%0d exp=61087", last_addr); end
    endtask

    task automatic test_clip();
        bit ok;
        push(8'd0, 16'd470, 16'd260, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clip_pop got=timeout exp=dequeue"); end
        wait_done(1200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clip_done got=timeout exp=sprite_done"); end
        checks++; if (wr_cnt !== 120) begin errors++; $display("FAIL clip_writes got=%0d exp=120", wr_cnt); end
        checks++; if (oob !== 0) begin errors++; $display("FAIL clip_oob got=%0d exp=0", oob); end
        checks++; if (first_addr !== 17'd125270) begin errors++; $display("FAIL clip_first got=%0d exp=125270", first_addr); end
        checks++; if (last_addr !== 17'd130559) begin errors++; $display("FAIL clip_last got=%0d exp=130559", last_addr); end
        checks++; if (done_cyc - pop_cyc !== 1028) begin errors++; $display("FAIL clip_duration got=%0d exp=1028", done_cyc - pop_cyc); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int p0;
        p0 = pops;
        push(8'd1, 16'd10, 16'd10, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_pop got=timeout exp=dequeue"); end
        repeat (100) @(negedge clock);
        enable = 1'b0;
        sprite_id = 8'd9; sprite_x = 16'd0; sprite_y = 16'd0; sprite_scale = 8'd0;
        is_empty = 1'b0;
        wait_done(1200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_done got=timeout exp=sprite_done"); end
        repeat (50) @(negedge clock);
        checks++; if (wr_cnt !== 1024) begin errors++; $display("FAIL drop_writes got=%0d exp=1024", wr_cnt); end
        checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL drop_pops got=%0d exp=1", pops - p0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", busy); end
        is_empty = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        push(8'd2, 16'd50, 16'd50, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_pop got=timeout exp=dequeue"); end
        repeat (300) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rstmid_fb_we got=%b exp=0", fb_we); end
        checks++; if (fb_addr !== 17'd0) begin errors++; $display("FAIL rstmid_fb_addr got=%0d exp=0", fb_addr); end
        checks++; if (fb_data !== 8'd0) begin errors++; $display("FAIL rstmid_fb_data got=%0d exp=0", fb_data); end
        checks++; if (rom_addr !== 18'd0) begin errors++; $display("FAIL rstmid_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (dequeue !== 1'b0) begin errors++; $display("FAIL rstmid_dequeue got=%b exp=0", dequeue); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        push(8'd3, 16'd100, 16'd40, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_pop2 got=timeout exp=dequeue"); end
        wait_done(1200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_done got=timeout exp=sprite_done"); end
        checks++; if (first_addr !== 17'd19300) begin errors++; $display("FAIL rstmid_first got=%0d exp=19300", first_addr); end
        checks++; if (wr_cnt !== 1024) begin errors++; $display("FAIL rstmid_writes got=%0d exp=1024", wr_cnt); end
        checks++; if (first_we_cyc - pop_cyc !== 4) begin errors++; $display("FAIL rstmid_lat got=%0d exp=4", first_we_cyc - pop_cyc); end
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b1;
        is_empty = 1'b1;
        sprite_id = 8'd0;
        sprite_x = 16'd0;
        sprite_y = 16'd0;
        sprite_scale = 8'd0;
        test_reset();
        test_no_pop();
        test_opaque();
        test_transparent();
        test_scale1();
        test_scale_clamp();
        test_clip();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
